// File: rtl/banded_sw_engine.sv
// Banded Smith-Waterman engine: one query row per cycle inside the band |j-i|<=W.
// Define BSW_TRACE_EN to build the traceback pointer memory and the aligned-pair stream.
module banded_sw_engine #(
    parameter int W        = 2,
    parameter int L        = 16,
    parameter int SW       = 8,
    parameter int MATCH    = 2,
    parameter int MISMATCH = 1,
    parameter int GAP      = 1,
    localparam int LW      = $clog2(L + 1)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [LW-1:0]   r_len,
    input  logic [LW-1:0]   q_len,
    input  logic [3*L-1:0]  R,
    input  logic [3*L-1:0]  Q,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [SW-1:0]   score,
    output logic [LW-1:0]   end_i,
    output logic [LW-1:0]   end_j,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      out_r,
    output logic [2:0]      out_q,
    output logic            out_last
);
    // state  | meaning
    // S_IDLE | waiting for start
    // S_LOAD | length check, clear best cell and previous row
    // S_FILL | compute one band row per cycle
    // S_TB   | stream aligned pairs back from the best cell
    // S_DONE | one-cycle done pulse
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FILL, S_TB, S_DONE} state_t;

    localparam int NB = 2 * W + 1;
    localparam int AW = $clog2(L);
    localparam logic signed [SW+1:0] S_MAT = (SW+2)'(MATCH);
    localparam logic signed [SW+1:0] S_MIS = (SW+2)'(MISMATCH);
    localparam logic signed [SW+1:0] S_GAP = (SW+2)'(GAP);
    localparam logic signed [SW+1:0] H_MAX = (SW+2)'((1 << SW) - 1);

    state_t         state_q, state_d;
    logic [3*L-1:0] r_q, q_q;
    logic [LW-1:0]  rlen_q, qlen_q, row_q;
    logic [SW-1:0]  best_q, best_d;
    logic [LW-1:0]  bi_q, bi_d, bj_q, bj_d;
    logic           err_q, len_bad, tb_fin;
    // prev_q[NB] and h_ext[0] are permanent zeros so band edges need no special case
    logic [SW-1:0]  prev_q [NB+1];
    logic [SW-1:0]  h_ext  [NB+1];
    logic [1:0]     p_row  [NB];

    function automatic logic [2:0] base_at(input logic [3*L-1:0] seq, input int pos);
        base_at = 3'b111;
        for (int k = 0; k < L; k++)
            if (pos == k + 1) base_at = seq[3*k +: 3];
    endfunction

    function automatic logic is_match(input logic [2:0] a, input logic [2:0] b);
        is_match = (a == b) && (a != 3'b111);
    endfunction

    assign len_bad = (rlen_q == '0) || (int'(rlen_q) > L) || (qlen_q == '0) || (int'(qlen_q) > L);

    always_comb begin
        logic signed [SW+1:0] v_d, v_u, v_l, v_m;
        logic [1:0] p;
        int jj;
        v_d = '0; v_u = '0; v_l = '0; v_m = '0; p = 2'b00; jj = 0;
        best_d = best_q;
        bi_d   = bi_q;
        bj_d   = bj_q;
        for (int k = 0; k <= NB; k++) h_ext[k] = '0;
        for (int k = 0; k < NB; k++) p_row[k] = 2'b00;
        for (int k = 0; k < NB; k++) begin
            jj = int'(row_q) + k - W;
            if (jj >= 1 && jj <= int'(rlen_q)) begin
                v_d = $signed({2'b00, prev_q[k]})
                      + (is_match(base_at(r_q, jj), base_at(q_q, int'(row_q))) ? S_MAT : -S_MIS);
                v_u = $signed({2'b00, prev_q[k+1]}) - S_GAP;
                v_l = $signed({2'b00, h_ext[k]}) - S_GAP;
                v_m = v_d;
                p   = 2'b01;
                if (v_u > v_m) begin v_m = v_u; p = 2'b10; end
                if (v_l > v_m) begin v_m = v_l; p = 2'b11; end
                if (v_m <= 0) begin v_m = '0; p = 2'b00; end
                if (v_m > H_MAX) v_m = H_MAX;
                h_ext[k+1] = v_m[SW-1:0];
                p_row[k]   = p;
                // strict compare keeps the earliest cell on ties
                if (h_ext[k+1] > best_d) begin
                    best_d = h_ext[k+1];
                    bi_d   = row_q;
                    bj_d   = LW'(jj);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_LOAD;
            S_LOAD: state_d = len_bad ? S_DONE : S_FILL;
            S_FILL: begin
`ifdef BSW_TRACE_EN
                if (row_q == qlen_q) state_d = S_TB;
`else
                if (row_q == qlen_q) state_d = S_DONE;
`endif
            end
            S_TB:   if (tb_fin) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            rlen_q  <= '0;
            qlen_q  <= '0;
            row_q   <= '0;
            best_q  <= '0;
            bi_q    <= '0;
            bj_q    <= '0;
            err_q   <= 1'b0;
            for (int k = 0; k <= NB; k++) prev_q[k] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (start) begin
                    r_q    <= R;
                    q_q    <= Q;
                    rlen_q <= r_len;
                    qlen_q <= q_len;
                    err_q  <= 1'b0;
                end
                S_LOAD: begin
                    best_q <= '0;
                    bi_q   <= '0;
                    bj_q   <= '0;
                    row_q  <= LW'(1);
                    err_q  <= len_bad;
                    for (int k = 0; k <= NB; k++) prev_q[k] <= '0;
                end
                S_FILL: begin
                    best_q <= best_d;
                    bi_q   <= bi_d;
                    bj_q   <= bj_d;
                    row_q  <= row_q + LW'(1);
                    for (int k = 0; k < NB; k++) prev_q[k] <= h_ext[k+1];
                end
                default: ;
            endcase
        end
    end

`ifdef BSW_TRACE_EN
    logic [1:0]    ptr_q [L][NB];
    logic [LW-1:0] tbi_q, tbj_q, nxi, nxj;
    logic [1:0]    cur_p;
    logic          tb_valid, beat, last;

    function automatic logic [1:0] ptr_at(input logic [LW-1:0] i, input logic [LW-1:0] j);
        int d;
        d = int'(j) - int'(i) + W;
        ptr_at = 2'b00;
        for (int r = 0; r < L; r++)
            for (int k = 0; k < NB; k++)
                if (int'(i) == r + 1 && d == k && j != '0) ptr_at = ptr_q[r][k];
    endfunction

    always_ff @(posedge clk) begin
        if (state_q == S_FILL)
            for (int k = 0; k < NB; k++) ptr_q[AW'(row_q - LW'(1))][k] <= p_row[k];
    end

    always_comb begin
        cur_p = ptr_at(tbi_q, tbj_q);
        nxi   = (cur_p == 2'b01 || cur_p == 2'b10) ? tbi_q - LW'(1) : tbi_q;
        nxj   = cur_p[0] ? tbj_q - LW'(1) : tbj_q;
        last  = (nxi == '0) || (nxj == '0) || (ptr_at(nxi, nxj) == 2'b00);
    end

    assign tb_valid  = (state_q == S_TB) && (best_q != '0);
    assign beat      = tb_valid && out_ready;
    assign tb_fin    = (state_q == S_TB) && ((best_q == '0) || (beat && last));
    assign out_valid = tb_valid;
    assign out_last  = tb_valid && last;
    assign out_r     = !tb_valid ? 3'b000 : (cur_p == 2'b10) ? 3'b111 : base_at(r_q, int'(tbj_q));
    assign out_q     = !tb_valid ? 3'b000 : (cur_p == 2'b11) ? 3'b111 : base_at(q_q, int'(tbi_q));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tbi_q <= '0;
            tbj_q <= '0;
        end else if (state_q == S_FILL) begin
            tbi_q <= bi_d;
            tbj_q <= bj_d;
        end else if (beat) begin
            tbi_q <= nxi;
            tbj_q <= nxj;
        end
    end
`else
    logic unused_ready;
    logic unused_ptr;
    assign unused_ready = out_ready;
    always_comb begin
        unused_ptr = 1'b0;
        for (int k = 0; k < NB; k++) unused_ptr = unused_ptr ^ (^p_row[k]);
    end
    assign tb_fin    = 1'b0;
    assign out_valid = 1'b0;
    assign out_r     = 3'b000;
    assign out_q     = 3'b000;
    assign out_last  = 1'b0;
`endif

    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);
    assign err   = err_q;
    assign score = best_q;
    assign end_i = bi_q;
    assign end_j = bj_q;
endmodule

// File: tb/tb_banded_sw_engine.sv
// Directed bench for banded_sw_engine; expectations hand-computed for W=2, L=16, SW=8.
// Expectations follow BSW_TRACE_EN (traceback stream) or its absence (score-only).
module tb_banded_sw_engine;
    localparam int L  = 16;
    localparam int LW = 5;
    localparam int SW = 8;
`ifdef BSW_TRACE_EN
    localparam int NP = 4;
`else
    localparam int NP = 0;
`endif

    logic           clk = 1'b0;
    logic           reset_n, start, out_ready;
    logic [LW-1:0]  r_len, q_len;
    logic [3*L-1:0] R, Q;
    logic           busy, done, err, out_valid, out_last;
    logic [SW-1:0]  score;
    logic [LW-1:0]  end_i, end_j;
    logic [2:0]     out_r, out_q;

    int n_checks = 0;
    int n_errors = 0;

    logic [2:0] br [32];
    logic [2:0] bq [32];
    logic       bl [32];
    int         nb, first_valid, done_cyc;

    banded_sw_engine dut (
        .clk(clk), .reset_n(reset_n), .start(start), .r_len(r_len), .q_len(q_len),
        .R(R), .Q(Q), .busy(busy), .done(done), .err(err), .score(score),
        .end_i(end_i), .end_j(end_j), .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_q(out_q), .out_last(out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3*L-1:0] pack(input string s);
        logic [2:0] b;
        pack = '0;
        for (int k = 0; k < s.len(); k++) begin
            case (s[k])
                "A": b = 3'd0;
                "C": b = 3'd1;
                "G": b = 3'd2;
                "T": b = 3'd3;
                default: b = 3'b111;
            endcase
            pack[3*k +: 3] = b;
        end
    endfunction

    // er/eq hold the expected pairs, first emitted pair in the top 3 bits
    task automatic check_pairs(input string tag, input int n, input logic [11:0] er, input logic [11:0] eq);
        check($sformatf("%s_nbeats", tag), 32'(nb), 32'(n));
        for (int k = 0; k < n && k < nb; k++) begin
            check($sformatf("%s_r%0d", tag, k), 32'(br[k]), 32'(er[11-3*k -: 3]));
            check($sformatf("%s_q%0d", tag, k), 32'(bq[k]), 32'(eq[11-3*k -: 3]));
            check($sformatf("%s_last%0d", tag, k), 32'(bl[k]), 32'(k == n - 1));
        end
    endtask

    task automatic run_job(input string rs, input string qs, input int rl, input int ql,
                           input int stall, input int hold);
        logic [7:0] held;
        int cyc;
        nb = 0; first_valid = -1; done_cyc = -1; held = '0; cyc = 0;
        @(negedge clk);
        R = pack(rs); Q = pack(qs); r_len = LW'(rl); q_len = LW'(ql);
        start = 1'b1;
        out_ready = (stall == 0);
        while (done_cyc < 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (cyc > hold) start = 1'b0;
            if (stall != 0 && first_valid >= 0 && cyc > first_valid && cyc <= first_valid + 2)
                check($sformatf("stall_hold_c%0d", cyc), 32'({out_r, out_q, out_last, out_valid}), 32'(held));
            if (out_valid) begin
                if (first_valid < 0) begin
                    first_valid = cyc;
                    held = {out_r, out_q, out_last, 1'b1};
                end
                if (out_ready && nb < 32) begin
                    br[nb] = out_r; bq[nb] = out_q; bl[nb] = out_last;
                    nb++;
                end
            end
            if (done) done_cyc = cyc;
            out_ready = (stall == 0) || (first_valid >= 0 && cyc >= first_valid + 2);
        end
        check("job_done_seen", 32'(done_cyc >= 0), 32'd1);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; out_ready = 1'b0;
        r_len = '0; q_len = '0; R = '0; Q = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_score", 32'(score), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        reset_n = 1'b1;

        // identical sequences: full diagonal
        run_job("ACGT", "ACGT", 4, 4, 0, 0);
        check("c1_score", 32'(score), 32'd8);
        check("c1_end_i", 32'(end_i), 32'd4);
        check("c1_end_j", 32'(end_j), 32'd4);
        check("c1_err", 32'(err), 32'd0);
        check_pairs("c1", NP, 12'h688, 12'h688);
`ifdef BSW_TRACE_EN
        check("c1_first_valid", 32'(first_valid), 32'd6);
        check("c1_done_cyc", 32'(done_cyc), 32'd10);
`else
        check("c1_done_cyc", 32'(done_cyc), 32'd6);
`endif

        // one query base deleted from the reference: up move in the middle
        run_job("ACT", "ACGT", 3, 4, 0, 0);
        check("c2_score", 32'(score), 32'd5);
        check("c2_end_i", 32'(end_i), 32'd4);
        check("c2_end_j", 32'(end_j), 32'd3);
        check_pairs("c2", NP, 12'h7C8, 12'h688);

        // nothing matches: zero score, no beats
        run_job("AAAA", "CCCC", 4, 4, 0, 0);
        check("c3_score", 32'(score), 32'd0);
        check("c3_end_i", 32'(end_i), 32'd0);
        check("c3_err", 32'(err), 32'd0);
        check("c3_nbeats", 32'(nb), 32'd0);

        // sink stalls three cycles on the first pair
        run_job("ACGT", "ACGT", 4, 4, 1, 0);
        check("c4_score", 32'(score), 32'd8);
        check_pairs("c4", NP, 12'h688, 12'h688);
`ifdef BSW_TRACE_EN
        check("c4_first_valid", 32'(first_valid), 32'd6);
        check("c4_done_cyc", 32'(done_cyc), 32'd13);
`endif

        // N never matches, not even N
        run_job("ANGT", "ANGT", 4, 4, 0, 0);
        check("cn_score", 32'(score), 32'd5);
        check("cn_end_i", 32'(end_i), 32'd4);
        check("cn_end_j", 32'(end_j), 32'd4);
        check_pairs("cn", NP, 12'h6B8, 12'h6B8);

        // zero query length
        run_job("ACGT", "ACGT", 4, 0, 0, 0);
        check("e1_err", 32'(err), 32'd1);
        check("e1_score", 32'(score), 32'd0);
        check("e1_done_cyc", 32'(done_cyc), 32'd2);
        check("e1_nbeats", 32'(nb), 32'd0);

        // reference too long; start held high through LOAD and DONE must be ignored
        run_job("ACGT", "ACGT", 17, 4, 0, 2);
        check("e2_err", 32'(err), 32'd1);
        check("e2_score", 32'(score), 32'd0);
        check("e2_done_cyc", 32'(done_cyc), 32'd2);
        check("e2_nbeats", 32'(nb), 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("e2_idle_after", 32'(busy), 32'd0);
        check("e2_err_held", 32'(err), 32'd1);

        // reset in the middle of a job
        @(negedge clk);
        R = pack("ACGT"); Q = pack("ACGT"); r_len = 5'd4; q_len = 5'd4;
        start = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
`ifdef BSW_TRACE_EN
        repeat (6) @(negedge clk);
        check("mr_valid_before", 32'(out_valid), 32'd1);
`else
        repeat (3) @(negedge clk);
        check("mr_busy_before", 32'(busy), 32'd1);
`endif
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_valid", 32'(out_valid), 32'd0);
        check("mr_score", 32'(score), 32'd0);
        @(negedge clk);
        check("mr_stays_idle", 32'(busy), 32'd0);
        out_ready = 1'b1;

        run_job("ACGT", "ACGT", 4, 4, 0, 0);
        check("c1b_score", 32'(score), 32'd8);
        check("c1b_err_cleared", 32'(err), 32'd0);
        check_pairs("c1b", NP, 12'h688, 12'h688);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
